// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed-priority grant (lowest index wins).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Default data width and its byte-strobe width.
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int STRB_WIDTH      = DATA_WIDTH_DFLT / 8;

  // Byte-strobe width for an arbitrary data width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Width of an encoded requester index.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the memory arbiter.
// slave  : arbiter view (accepts requests, drives the memory port).
// master : environment view (requesters and the shared memory).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  import mem_arb_pkg::*;

  localparam int STRB_W = strb_width(DATA_WIDTH);

  // Requester side: slice i belongs to requester i.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0]     req_wstrb;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  // Shared memory port.
  logic                          mem_valid;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [STRB_W-1:0]             mem_wstrb;
  logic                          mem_write;
  logic                          mem_ready;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, req_write,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_write,
    input  mem_ready, mem_rdata
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, req_write,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_write,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the memory arbiter.
// Default: round-robin, search starts at rr_ptr and wraps.
// MEM_ARB_FIXED_PRIO_EN: fixed priority, lowest asserted index wins (no rr_ptr).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   rr_ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Walk the requesters once from the start index; the first one asserted wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the search, so no path leaves
    // a variable unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    idx     = '0;
`else
    idx     = rr_ptr;
`endif
    // NOTE: blocking assignments here, because idx and gnt_any must carry
    // their updated values into the next loop iteration within one evaluation.
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port among NUM_REQ requesters
// (index 0 = instruction fetch, 1 = load/store). One transaction in flight;
// grant is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int IDX_W  = idx_width(NUM_REQ);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // State encodings kept as plain constants for legacy netlists.
  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_BUSY = ARB_BUSY;
  localparam logic [1:0] ST_RESP = ARB_RESP;

  logic [1:0]            state;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      rr_ptr;
`endif

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;
  logic                  sel_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .rr_ptr  (rr_ptr),
`endif
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // A request is taken only while idle and out of reset.
  assign accept        = (state == ST_IDLE) && arb_any && !rst;
  assign bus.req_ready = accept ? arb_gnt : '0;

  // Pick the winner's request fields out of the packed requester buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
        sel_write = bus.req_write[i];
      end
    end
  end

  // Memory port is driven straight from the latched transaction.
  assign bus.mem_valid = (state == ST_BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_write = write_q;
  assign bus.rsp_rdata = rdata_q;

  // Completion pulse goes only to the requester that owns the transaction.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = (state == ST_RESP) && (gnt_idx == IDX_W'(i));
    end
  end

  // Transaction FSM: latch on accept, wait for memory, pulse the response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= ST_IDLE;
      gnt_idx <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_write ? sel_wstrb : '0;
            write_q <= sel_write;
            gnt_idx <= arb_idx;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr  <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
`endif
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // No timeout: the memory may stall indefinitely.
          if (bus.mem_ready) begin
            rdata_q <= write_q ? '0 : bus.mem_rdata;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(3))  bus3 ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Requester obligation: a pending request holds its fields until accepted.
  for (genvar gi = 0; gi < NR; gi++) begin : g_obligation
    assert property (@(posedge clk) disable iff (rst)
      (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
        (bus.req_valid[gi] && $stable(bus.req_addr[gi*AW +: AW]) &&
         $stable(bus.req_wdata[gi*DW +: DW]) && $stable(bus.req_wstrb[gi*SW +: SW]) &&
         $stable(bus.req_write[gi])))
      else $error("requester %0d dropped or changed a pending request", gi);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester pool.
  logic [NR-1:0] pend;
  logic [AW-1:0] p_addr  [NR];
  logic [DW-1:0] p_wdata [NR];
  logic [SW-1:0] p_wstrb [NR];
  logic          p_write [NR];

  // Stimulus knobs.
  int          auto_rate;   // percent chance per cycle of a new request
  int          rdy_mode;    // 0 random, 1 always, 2 at busy cycle rdy_delay, 3 never
  int          rdy_delay;
  bit          use_fixed;
  logic [DW-1:0] fixed_rdata;
  bit          rst_req;

  // Reference model: one outstanding transaction, response one cycle after ready.
  bit            m_busy, m_resp;
  int            m_gnt, m_rr, m_busy_cyc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic          m_write;

  int cyc;
  int grant_log[$];
  int grant_cyc[$];

  function automatic int pick(input logic [NR-1:0] p, input int rr);
    int start;
`ifdef MEM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    for (int k = 0; k < NR; k++) begin
      if (p[(start + k) % NR]) return (start + k) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_index(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic new_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic w);
    pend[i]    = 1'b1;
    p_addr[i]  = a;
    p_wdata[i] = d;
    p_wstrb[i] = s;
    p_write[i] = w;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_resp = 1'b0; m_gnt = 0; m_rr = 0; m_busy_cyc = 0;
    m_rdata = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step();
    int w;
    logic [NR-1:0] exp_ready, exp_rsp;
    bit done;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < auto_rate)
        new_req(i, $urandom, $urandom, SW'($urandom), 1'($urandom));
    end
    bus.req_valid = pend;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW]  = p_addr[i];
      bus.req_wdata[i*DW +: DW] = p_wdata[i];
      bus.req_wstrb[i*SW +: SW] = p_wstrb[i];
      bus.req_write[i]          = p_write[i];
    end
    case (rdy_mode)
      0:       bus.mem_ready = 1'($urandom_range(0, 1));
      1:       bus.mem_ready = 1'b1;
      2:       bus.mem_ready = m_busy && (m_busy_cyc == rdy_delay);
      default: bus.mem_ready = 1'b0;
    endcase
    bus.mem_rdata = use_fixed ? fixed_rdata : DW'($urandom);
    #1;
    exp_rsp = m_resp ? (NR'(1) << m_gnt) : '0;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
    check("mem_valid", 64'(bus.mem_valid), 64'(m_busy));
    if (m_busy) begin
      check("mem_addr",  64'(bus.mem_addr),  64'(m_addr));
      check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      check("mem_wstrb", 64'(bus.mem_wstrb), 64'(m_wstrb));
      check("mem_write", 64'(bus.mem_write), 64'(m_write));
    end
    w = (!rst && !m_busy && !m_resp) ? pick(pend, m_rr) : -1;
    exp_ready = (w >= 0) ? (NR'(1) << w) : '0;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (|bus.req_ready) begin
      grant_log.push_back(oh_index(8'(bus.req_ready)));
      grant_cyc.push_back(cyc);
    end
    if (rst) begin
      model_reset();
    end else begin
      done = m_busy && bus.mem_ready;
      if (done) m_rdata = m_write ? '0 : bus.mem_rdata;
      m_resp = done;
      if (done) m_busy = 1'b0;
      else if (m_busy) m_busy_cyc++;
      if (w >= 0) begin
        m_busy     = 1'b1;
        m_busy_cyc = 1;
        m_gnt      = w;
        m_addr     = p_addr[w];
        m_wdata    = p_wdata[w];
        m_wstrb    = p_write[w] ? p_wstrb[w] : '0;
        m_write    = p_write[w];
        pend[w]    = 1'b0;
        m_rr       = (w + 1) % NR;
      end
    end
  endtask

  // Run until no request is pending and the arbiter is idle.
  task automatic drain();
    int n;
    auto_rate = 0;
    rdy_mode  = 1;
    n = 0;
    while ((pend != '0 || m_busy || m_resp) && n < 200) begin
      step();
      n++;
    end
    if (pend != '0 || m_busy || m_resp) check("drain_timeout", 64'd1, 64'd0);
  endtask

  int exp4[4];
  int g3[$];
  int last_g3;

  initial begin
    pend = '0;
    for (int i = 0; i < NR; i++) begin
      p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0; p_write[i] = 1'b0;
    end
    bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.req_write = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    bus3.req_valid = '0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_wstrb = '0;
    bus3.req_write = '0; bus3.mem_ready = 1'b0; bus3.mem_rdata = '0;
    auto_rate = 0; rdy_mode = 1; rdy_delay = 1; use_fixed = 1'b0; fixed_rdata = '0;
    rst_req = 1'b1; cyc = 0;
    model_reset();
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_write = 1'b0;

    // Reset: requests present but never accepted while rst is high.
    new_req(0, 32'h10, 32'h1, 4'hF, 1'b0);
    new_req(1, 32'h20, 32'h2, 4'hF, 1'b1);
    repeat (3) step();
    check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    check("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    rst_req = 1'b0;
    drain();

    // Single read with memory completing in the third busy cycle.
    use_fixed = 1'b1; fixed_rdata = 32'hDEADBEEF;
    rdy_mode = 2; rdy_delay = 3;
    new_req(0, 32'h100, 32'h0, 4'hF, 1'b0);
    step();
    check("rd_ready", 64'(bus.req_ready), 64'b01);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("rd_mem_valid", 64'(bus.mem_valid), 64'd1);
      check("rd_mem_addr",  64'(bus.mem_addr),  64'h100);
      check("rd_mem_write", 64'(bus.mem_write), 64'd0);
    end
    step();
    check("rd_rsp_valid", 64'(bus.rsp_valid), 64'b01);
    check("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
    drain();

    // Write from the load/store port, memory ready immediately.
    rdy_mode = 1;
    new_req(1, 32'h204, 32'h0000ABCD, 4'b0011, 1'b1);
    step();
    step();
    check("wr_mem_write", 64'(bus.mem_write), 64'd1);
    check("wr_mem_wstrb", 64'(bus.mem_wstrb), 64'b0011);
    check("wr_mem_wdata", 64'(bus.mem_wdata), 64'h0000ABCD);
    step();
    check("wr_rsp_valid", 64'(bus.rsp_valid), 64'b10);
    check("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    step();
    check("wr_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    drain();

    // Reset in the second busy cycle abandons the transaction.
    rdy_mode = 3;
    new_req(0, 32'h300, 32'h0, 4'hF, 1'b0);
    step();
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    check("rstmid_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    new_req(1, 32'h400, 32'h0, 4'hF, 1'b0);
    step();
    check("rstmid_req1_first", 64'(bus.req_ready), 64'b10);
    drain();

    // Spurious memory ready while idle is ignored; later read sees its own data.
    use_fixed = 1'b0;
    rdy_mode = 1;
    repeat (3) begin
      step();
      check("spur_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("spur_mem_valid", 64'(bus.mem_valid), 64'd0);
    end
    rdy_mode = 0;
    new_req(0, 32'h500, 32'h0, 4'hF, 1'b0);
    repeat (20) step();
    drain();

    // Contention from reset: both requesters hold valid continuously.
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    auto_rate = 100;
    rdy_mode = 1;
    repeat (14) step();
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp4 = '{0, 0, 0, 0};
`else
    exp4 = '{0, 1, 0, 1};
`endif
    if (grant_log.size() < 4) begin
      check("cont_grant_count", 64'(grant_log.size()), 64'd4);
    end else begin
      for (int k = 0; k < 4; k++) check("cont_grant_order", 64'(grant_log[k]), 64'(exp4[k]));
      for (int k = 0; k < 3; k++)
        check("cont_spacing", 64'(grant_cyc[k+1] - grant_cyc[k]), 64'd3);
    end
    drain();

    // Random traffic with random memory latency.
    auto_rate = 40;
    rdy_mode = 0;
    repeat (600) step();
    drain();

    // Three requesters, all requesting continuously: order wraps 0,1,2,0.
    last_g3 = -1;
    for (int n = 0; n < 40 && g3.size() < 4; n++) begin
      @(negedge clk);
      bus3.req_valid = 3'b111;
      bus3.mem_ready = 1'b1;
      bus3.mem_rdata = DW'($urandom);
      #1;
      if (bus3.rsp_valid != '0)
        check("wrap_rsp_owner", 64'(bus3.rsp_valid), 64'(3'b001 << last_g3));
      if (bus3.req_ready != '0) begin
        last_g3 = oh_index(8'(bus3.req_ready));
        g3.push_back(last_g3);
      end
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp4 = '{0, 0, 0, 0};
`else
    exp4 = '{0, 1, 2, 0};
`endif
    if (g3.size() < 4) begin
      check("wrap_grant_count", 64'(g3.size()), 64'd4);
    end else begin
      for (int k = 0; k < 4; k++) check("wrap_grant_order", 64'(g3[k]), 64'(exp4[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
